nf_axis_stats_counters: RTL and testbench
=========================================

# nf_axis_stats_counters

Parametrised multi-channel AXI-Stream statistics block: passively taps up to NUM_CH stream interfaces (10GE RX/TX, DMA ports) and keeps per-channel packet and byte counters with sticky overflow flags, selectable saturate-or-wrap arithmetic and atomic read-and-clear. It sits beside the interface wrappers in the core_clk domain. Its read port feeds the cpu_regs register file, replacing hand-written per-interface pktin/pktout logic.

## Interface
- NUM_CH, 4: number of monitored streams (1..16).
- C_DATA_WIDTH, 64: monitored tdata width in bits; KEEP_W = C_DATA_WIDTH/8.
- C_CNT_WIDTH, 32: counter width including nothing else; overflow flag is separate.
- C_SATURATE, 1: 1 = hold at all-ones on overflow, 0 = wrap.
- Clock and reset: one clock; reset is synchronous and active-high.
- core_clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- mon_tvalid  in  NUM_CH  per-channel tvalid tap.
- mon_tready  in  NUM_CH  per-channel tready tap.
- mon_tlast  in  NUM_CH  per-channel tlast tap.
- mon_tkeep  in  NUM_CH*KEEP_W  per-channel tkeep; channel i at [i*KEEP_W +: KEEP_W].
- clear_all  in  1  one-cycle pulse; zero all counters and flags.
- rd_req  in  1  read strobe.
- rd_ch  in  clog2(NUM_CH) (min 1)  channel to read.
- rd_sel  in  1  0 = packet counter, 1 = byte counter.
- rd_clear  in  1  with rd_req: clear the selected counter and flag after sampling.
- rd_valid  out  1  read data valid, one-cycle pulse.
- rd_data  out  C_CNT_WIDTH  counter value.
- rd_ovf  out  1  sticky overflow flag of the read counter.

## Operation
- Beat = mon_tvalid[i] & mon_tready[i]. Packet event = beat & mon_tlast[i]. Byte increment = popcount(tkeep) on each beat. Non-contiguous tkeep is counted bit-for-bit.
- Stage 1 registers the beat, packet and popcount per channel. Stage 2 updates the counters.
- Overflow: if the sum exceeds 2^C_CNT_WIDTH-1, the flag is set and stays set until cleared.
  - C_SATURATE=1: counter = all-ones.
  - C_SATURATE=0: counter = sum mod 2^C_CNT_WIDTH.
- A counter already at all-ones with C_SATURATE=1 stays there and keeps the flag set.
- Read: on rd_req, the selected counter and flag are sampled from the stage-2 registers. rd_ch >= NUM_CH returns rd_data=0 and rd_ovf=0, and the clear is ignored.
- Read-clear colliding with an increment on the same counter in the same cycle:
  - the returned value is the pre-increment value;
  - the counter becomes the increment amount (no event is lost);
  - the flag becomes 0.
- clear_all has priority over everything. Counters and flags go to 0, and any stage-2 increment in that cycle is discarded. A read in the same cycle still returns the pre-clear value.
- rst clears stage-1 registers, counters and flags. Beats in flight in stage 1 are discarded.

## Timing
- Reset values: rd_valid=0, rd_data=0, rd_ovf=0; all counters and flags 0.
- Beat in cycle T is visible to a read issued in cycle T+2. The read response appears in cycle T+3.
- Read latency: rd_valid asserts exactly 1 cycle after rd_req. Back-to-back rd_req every cycle is supported with no stall.
- No handshake back-pressure: the block never drives tready and accepts every tap every cycle.

## Configuration
- STATS_BYTE_COUNT_EN defined: byte counters, popcount logic and byte overflow flags are built.
- Not defined: only packet counters exist. Reads with rd_sel=1 return rd_data=0 and rd_ovf=0, and rd_clear has no effect. The mon_tkeep input is left unused.

## Structure
- Package nf_stats_pkg holds:
  - the RD_SEL_PKT=0 and RD_SEL_BYTE=1 constants;
  - the popcount function parameterised on KEEP_W;
  - the saturating/wrapping add function returning {ovf, sum}.
- Sub-module nf_stats_chan: one channel's stage-1 register, packet/byte counters and flags. It is instantiated NUM_CH times by generate. The top holds the read mux and the clear_all fan-out.

## Test plan
- Saturate: C_CNT_WIDTH=8, C_SATURATE=1; 300 single-beat packets on ch0 -> pkt read returns 255 with rd_ovf=1.
- Wrap: C_SATURATE=0, C_CNT_WIDTH=8; 300 packets on ch0 -> pkt read returns 44 with rd_ovf=1.
- Bytes: ch2 sends a 3-beat packet with tkeep FF, FF, 0F (20 bytes), while tready drops for one cycle mid-packet -> byte=20, pkt=1; ch0, ch1 and ch3 all read 0.
- Read-clear collision: ch1 pkt counter at 5; rd_req+rd_clear in the same cycle as a tlast beat reaching stage 2 -> rd_data=5, rd_ovf=0; the next read returns 1.
- clear_all with simultaneous traffic on all channels -> all reads return 0. rd_valid arrives 1 cycle after each rd_req.
- Out-of-range channel: rd_ch=NUM_CH -> rd_data=0, rd_ovf=0. rst mid-packet: counters read 0 afterwards.

Source files
------------

// File: rtl/nf_stats_pkg.sv
// Shared constants and arithmetic helpers for the AXI-Stream statistics counters.
package nf_stats_pkg;

    localparam logic RD_SEL_PKT  = 1'b0;
    localparam logic RD_SEL_BYTE = 1'b1;

    // Helpers work on fixed maximum widths; callers zero-extend and truncate.
    localparam int MAX_KEEP_W = 128;
    localparam int POP_RET_W  = 8;
    localparam int MAX_CNT_W  = 64;

    function automatic logic [POP_RET_W-1:0] popcount(
        input logic [MAX_KEEP_W-1:0] keep,
        input int                    keep_w
    );
        logic [POP_RET_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            if (i < keep_w) n = n + POP_RET_W'(keep[i]);
        end
        return n;
    endfunction

    // Returns {ovf, sum}; the sum is limited to 'width' bits, clamped or wrapped.
    function automatic logic [MAX_CNT_W:0] cnt_add(
        input logic [MAX_CNT_W-1:0] a,
        input logic [MAX_CNT_W-1:0] b,
        input int                   width,
        input logic                 saturate
    );
        logic [MAX_CNT_W:0] full;
        logic [MAX_CNT_W:0] lim;
        logic               ovf;
        full = {1'b0, a} + {1'b0, b};
        lim  = ((MAX_CNT_W+1)'(1) << width) - (MAX_CNT_W+1)'(1);
        ovf  = (full > lim);
        if (ovf) full = saturate ? lim : (full & lim);
        return {ovf, full[MAX_CNT_W-1:0]};
    endfunction

endpackage

// File: rtl/nf_stats_chan.sv
// One monitored stream: stage-1 beat capture and stage-2 packet/byte counters.
// Byte counters exist only when STATS_BYTE_COUNT_EN is defined.
module nf_stats_chan
    import nf_stats_pkg::*;
#(
    parameter int KEEP_W   = 8,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear_all,
    input  logic              i_tvalid,
    input  logic              i_tready,
    input  logic              i_tlast,
    input  logic [KEEP_W-1:0] i_tkeep,
    input  logic              i_rd_clr_pkt,
    input  logic              i_rd_clr_byte,
    output logic [CNT_W-1:0]  o_pkt_cnt,
    output logic              o_pkt_ovf,
    output logic [CNT_W-1:0]  o_byte_cnt,
    output logic              o_byte_ovf
);
    localparam logic SAT = (SATURATE != 0);

    logic               w_beat;
    logic               r_pkt;
    logic [CNT_W-1:0]   r_pkt_cnt;
    logic               r_pkt_ovf;
    logic [MAX_CNT_W:0] w_pkt_add;

    assign w_beat    = i_tvalid & i_tready;
    assign w_pkt_add = cnt_add(MAX_CNT_W'(r_pkt_cnt), MAX_CNT_W'(1), CNT_W, SAT);

    // A read-clear restarts the counter from the increment landing this cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pkt     <= 1'b0;
            r_pkt_cnt <= '0;
            r_pkt_ovf <= 1'b0;
        end else begin
            r_pkt <= w_beat & i_tlast;
            if (i_clear_all) begin
                r_pkt_cnt <= '0;
                r_pkt_ovf <= 1'b0;
            end else if (i_rd_clr_pkt) begin
                r_pkt_cnt <= CNT_W'(r_pkt);
                r_pkt_ovf <= 1'b0;
            end else if (r_pkt) begin
                r_pkt_cnt <= CNT_W'(w_pkt_add);
                r_pkt_ovf <= r_pkt_ovf | w_pkt_add[MAX_CNT_W];
            end
        end
    end

    assign o_pkt_cnt = r_pkt_cnt;
    assign o_pkt_ovf = r_pkt_ovf;

`ifdef STATS_BYTE_COUNT_EN
    localparam int POP_W = $clog2(KEEP_W + 1);

    logic [POP_W-1:0]   r_bytes;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic               r_byte_ovf;
    logic [MAX_CNT_W:0] w_byte_add;

    assign w_byte_add = cnt_add(MAX_CNT_W'(r_byte_cnt), MAX_CNT_W'(r_bytes), CNT_W, SAT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bytes    <= '0;
            r_byte_cnt <= '0;
            r_byte_ovf <= 1'b0;
        end else begin
            r_bytes <= w_beat ? POP_W'(popcount(MAX_KEEP_W'(i_tkeep), KEEP_W)) : '0;
            if (i_clear_all) begin
                r_byte_cnt <= '0;
                r_byte_ovf <= 1'b0;
            end else if (i_rd_clr_byte) begin
                r_byte_cnt <= CNT_W'(r_bytes);
                r_byte_ovf <= 1'b0;
            end else begin
                r_byte_cnt <= CNT_W'(w_byte_add);
                r_byte_ovf <= r_byte_ovf | w_byte_add[MAX_CNT_W];
            end
        end
    end

    assign o_byte_cnt = r_byte_cnt;
    assign o_byte_ovf = r_byte_ovf;
`else
    logic w_unused_byte;
    assign w_unused_byte = ^{i_tkeep, i_rd_clr_byte};
    assign o_byte_cnt    = '0;
    assign o_byte_ovf    = 1'b0;
`endif

endmodule

// File: rtl/nf_axis_stats_counters.sv
// Multi-channel AXI-Stream statistics taps with a registered read/read-clear port.
// Byte counters are built only when STATS_BYTE_COUNT_EN is defined.
module nf_axis_stats_counters
    import nf_stats_pkg::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int C_DATA_WIDTH = 64,
    parameter  int C_CNT_WIDTH  = 32,
    parameter  int C_SATURATE   = 1,
    localparam int KEEP_W       = C_DATA_WIDTH / 8,
    localparam int RD_CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_core_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        i_mon_tvalid,
    input  logic [NUM_CH-1:0]        i_mon_tready,
    input  logic [NUM_CH-1:0]        i_mon_tlast,
    input  logic [NUM_CH*KEEP_W-1:0] i_mon_tkeep,
    input  logic                     i_clear_all,
    input  logic                     i_rd_req,
    input  logic [RD_CH_W-1:0]       i_rd_ch,
    input  logic                     i_rd_sel,
    input  logic                     i_rd_clear,
    output logic                     o_rd_valid,
    output logic [C_CNT_WIDTH-1:0]   o_rd_data,
    output logic                     o_rd_ovf
);
    logic [C_CNT_WIDTH-1:0] w_pkt_cnt  [NUM_CH];
    logic [C_CNT_WIDTH-1:0] w_byte_cnt [NUM_CH];
    logic [NUM_CH-1:0]      w_pkt_ovf;
    logic [NUM_CH-1:0]      w_byte_ovf;
    logic [NUM_CH-1:0]      w_clr_pkt;
    logic [NUM_CH-1:0]      w_clr_byte;
    logic                   w_rd_clr;
    logic [C_CNT_WIDTH-1:0] w_sel_data;
    logic                   w_sel_ovf;
    logic                   r_rd_valid;
    logic [C_CNT_WIDTH-1:0] r_rd_data;
    logic                   r_rd_ovf;

    assign w_rd_clr = i_rd_req & i_rd_clear;

    // Out-of-range rd_ch matches no channel, so its clear is dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_clr_pkt[g]  = w_rd_clr & (i_rd_sel == RD_SEL_PKT)  & (i_rd_ch == RD_CH_W'(g));
        assign w_clr_byte[g] = w_rd_clr & (i_rd_sel == RD_SEL_BYTE) & (i_rd_ch == RD_CH_W'(g));

        nf_stats_chan #(
            .KEEP_W   (KEEP_W),
            .CNT_W    (C_CNT_WIDTH),
            .SATURATE (C_SATURATE)
        ) u_chan (
            .i_clk         (i_core_clk),
            .i_rst         (i_rst),
            .i_clear_all   (i_clear_all),
            .i_tvalid      (i_mon_tvalid[g]),
            .i_tready      (i_mon_tready[g]),
            .i_tlast       (i_mon_tlast[g]),
            .i_tkeep       (i_mon_tkeep[g*KEEP_W +: KEEP_W]),
            .i_rd_clr_pkt  (w_clr_pkt[g]),
            .i_rd_clr_byte (w_clr_byte[g]),
            .o_pkt_cnt     (w_pkt_cnt[g]),
            .o_pkt_ovf     (w_pkt_ovf[g]),
            .o_byte_cnt    (w_byte_cnt[g]),
            .o_byte_ovf    (w_byte_ovf[g])
        );
    end

    always_comb begin
        w_sel_data = '0;
        w_sel_ovf  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_rd_ch == RD_CH_W'(i)) begin
                if (i_rd_sel == RD_SEL_PKT) begin
                    w_sel_data = w_pkt_cnt[i];
                    w_sel_ovf  = w_pkt_ovf[i];
                end else begin
                    w_sel_data = w_byte_cnt[i];
                    w_sel_ovf  = w_byte_ovf[i];
                end
            end
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_ovf   <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_req;
            if (i_rd_req) begin
                r_rd_data <= w_sel_data;
                r_rd_ovf  <= w_sel_ovf;
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_rd_ovf   = r_rd_ovf;

endmodule

// File: tb/tb_nf_axis_stats_counters.sv
// Bench for nf_axis_stats_counters: a saturating 4-channel and a wrapping 3-channel instance
// share one stimulus stream and are checked against a delay-queue counting model.
module tb_nf_axis_stats_counters;

`ifdef STATS_BYTE_COUNT_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    typedef struct {
        int ch;
        bit sel;
        int exp_d;
        bit exp_o;
    } rd_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  tvalid, tready, tlast;
    logic [31:0] tkeep;
    logic        clear_all, rd_req, rd_sel, rd_clear;
    logic [1:0]  rd_ch;
    logic        s_valid, s_ovf, w_valid, w_ovf;
    logic [7:0]  s_data, w_data;

    int total = 0;
    int bad   = 0;

    longint cnt_p [2][4];
    longint cnt_b [2][4];
    longint pend_p [4];
    longint pend_b [4];

    always #5 clk = ~clk;

    nf_axis_stats_counters #(
        .NUM_CH(4), .C_DATA_WIDTH(64), .C_CNT_WIDTH(8), .C_SATURATE(1)
    ) dut_s (
        .i_core_clk(clk), .i_rst(rst),
        .i_mon_tvalid(tvalid), .i_mon_tready(tready), .i_mon_tlast(tlast),
        .i_mon_tkeep(tkeep), .i_clear_all(clear_all),
        .i_rd_req(rd_req), .i_rd_ch(rd_ch), .i_rd_sel(rd_sel), .i_rd_clear(rd_clear),
        .o_rd_valid(s_valid), .o_rd_data(s_data), .o_rd_ovf(s_ovf)
    );

    nf_axis_stats_counters #(
        .NUM_CH(3), .C_DATA_WIDTH(64), .C_CNT_WIDTH(8), .C_SATURATE(0)
    ) dut_w (
        .i_core_clk(clk), .i_rst(rst),
        .i_mon_tvalid(tvalid[2:0]), .i_mon_tready(tready[2:0]), .i_mon_tlast(tlast[2:0]),
        .i_mon_tkeep(tkeep[23:0]), .i_clear_all(clear_all),
        .i_rd_req(rd_req), .i_rd_ch(rd_ch), .i_rd_sel(rd_sel), .i_rd_clear(rd_clear),
        .o_rd_valid(w_valid), .o_rd_data(w_data), .o_rd_ovf(w_ovf)
    );

    function automatic int nch(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic longint shown(input longint c, input bit sat);
        if (c <= 255) return c;
        if (sat) return 255;
        return c % 256;
    endfunction

    function automatic int popcnt8(input logic [7:0] k);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(k[i]);
        return n;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // One clock: predict the read response from pre-edge model state, then advance the model.
    task automatic tick();
        logic [7:0] ed [2];
        logic       eo [2];
        bit         req;
        bit         clrp, clrb;
        longint     c;
        req = rd_req && !rst;
        for (int k = 0; k < 2; k++) begin
            ed[k] = 8'd0;
            eo[k] = 1'b0;
            if (req && int'(rd_ch) < nch(k) && (!rd_sel || BYTE_EN)) begin
                c     = rd_sel ? cnt_b[k][rd_ch] : cnt_p[k][rd_ch];
                eo[k] = (c > 255);
                ed[k] = 8'(shown(c, k == 0));
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int ch = 0; ch < nch(k); ch++) begin
                if (rst || clear_all) begin
                    cnt_p[k][ch] = 0;
                    cnt_b[k][ch] = 0;
                end else begin
                    clrp = rd_req && rd_clear && (int'(rd_ch) == ch) && !rd_sel;
                    clrb = rd_req && rd_clear && (int'(rd_ch) == ch) && rd_sel && BYTE_EN;
                    cnt_p[k][ch] = clrp ? pend_p[ch] : cnt_p[k][ch] + pend_p[ch];
                    cnt_b[k][ch] = clrb ? pend_b[ch] : cnt_b[k][ch] + pend_b[ch];
                end
            end
        end
        for (int ch = 0; ch < 4; ch++) begin
            if (rst) begin
                pend_p[ch] = 0;
                pend_b[ch] = 0;
            end else begin
                pend_p[ch] = (tvalid[ch] && tready[ch] && tlast[ch]) ? 1 : 0;
                pend_b[ch] = (tvalid[ch] && tready[ch]) ? popcnt8(tkeep[ch*8 +: 8]) : 0;
            end
        end
        @(posedge clk);
        #1;
        chk("s_rd_valid", 64'(s_valid), 64'(req));
        chk("w_rd_valid", 64'(w_valid), 64'(req));
        if (req) begin
            chk("model_s_data", 64'(s_data), 64'(ed[0]));
            chk("model_s_ovf",  64'(s_ovf),  64'(eo[0]));
            chk("model_w_data", 64'(w_data), 64'(ed[1]));
            chk("model_w_ovf",  64'(w_ovf),  64'(eo[1]));
        end
    endtask

    task automatic do_read(input int ch, input bit sel, input bit clr,
                           input int sd, input bit so, input int wd, input bit wo,
                           input string name);
        rd_req   = 1'b1;
        rd_ch    = 2'(ch);
        rd_sel   = sel;
        rd_clear = clr;
        tick();
        rd_req   = 1'b0;
        rd_clear = 1'b0;
        chk({name, "_s_data"}, 64'(s_data), 64'(sd));
        chk({name, "_s_ovf"},  64'(s_ovf),  64'(so));
        chk({name, "_w_data"}, 64'(w_data), 64'(wd));
        chk({name, "_w_ovf"},  64'(w_ovf),  64'(wo));
    endtask

    task automatic idle();
        tvalid = '0; tready = '0; tlast = '0; tkeep = '0;
    endtask

    initial begin
        rd_vec_t vclr  [8];
        rd_vec_t vbyte [8];
        for (int i = 0; i < 8; i++) vclr[i] = '{i / 2, 1'(i % 2), 0, 1'b0};
        vbyte[0] = '{0, 1'b0, 0, 1'b0};
        vbyte[1] = '{0, 1'b1, 0, 1'b0};
        vbyte[2] = '{1, 1'b0, 0, 1'b0};
        vbyte[3] = '{1, 1'b1, 0, 1'b0};
        vbyte[4] = '{2, 1'b0, 1, 1'b0};
        vbyte[5] = '{2, 1'b1, BYTE_EN ? 20 : 0, 1'b0};
        vbyte[6] = '{3, 1'b0, 0, 1'b0};
        vbyte[7] = '{3, 1'b1, 0, 1'b0};

        idle();
        rst = 1'b1; clear_all = 1'b0;
        rd_req = 1'b0; rd_ch = 2'd0; rd_sel = 1'b0; rd_clear = 1'b0;
        repeat (3) tick();
        chk("rst_s_valid", 64'(s_valid), 64'd0);
        chk("rst_s_data",  64'(s_data),  64'd0);
        chk("rst_s_ovf",   64'(s_ovf),   64'd0);
        chk("rst_w_valid", 64'(w_valid), 64'd0);
        chk("rst_w_data",  64'(w_data),  64'd0);
        chk("rst_w_ovf",   64'(w_ovf),   64'd0);
        rst = 1'b0;
        tick();

        // 300 single-beat, one-byte packets on ch0
        tvalid = 4'b0001; tready = 4'b0001; tlast = 4'b0001; tkeep = 32'h0000_0001;
        repeat (300) tick();
        idle();
        repeat (2) tick();
        do_read(0, 1'b0, 1'b0, 255, 1'b1, 44, 1'b1, "ovf_pkt");
        do_read(0, 1'b1, 1'b0, BYTE_EN ? 255 : 0, BYTE_EN, BYTE_EN ? 44 : 0, BYTE_EN, "ovf_byte");

        // traffic reaches stage 2 in the clear_all cycle; same-cycle read sees pre-clear value
        tvalid = 4'hF; tready = 4'hF; tlast = 4'hF; tkeep = 32'hFFFF_FFFF;
        tick();
        idle();
        clear_all = 1'b1;
        do_read(0, 1'b0, 1'b0, 255, 1'b1, 44, 1'b1, "pre_clear");
        clear_all = 1'b0;
        for (int i = 0; i < 8; i++)
            do_read(vclr[i].ch, vclr[i].sel, 1'b0, vclr[i].exp_d, vclr[i].exp_o,
                    vclr[i].exp_d, vclr[i].exp_o, $sformatf("clr%0d", i));

        // ch2: FF, (stall), FF, 0F with tlast
        tvalid = 4'b0100; tready = 4'b0100; tkeep = 32'h00FF_0000; tick();
        tready = 4'b0000; tick();
        tready = 4'b0100; tick();
        tlast = 4'b0100; tkeep = 32'h000F_0000; tick();
        idle();
        repeat (2) tick();
        for (int i = 0; i < 8; i++)
            do_read(vbyte[i].ch, vbyte[i].sel, 1'b0, vbyte[i].exp_d, vbyte[i].exp_o,
                    vbyte[i].exp_d, vbyte[i].exp_o, $sformatf("byte%0d", i));

        // read-clear collides with a packet reaching stage 2
        tvalid = 4'b0010; tready = 4'b0010; tlast = 4'b0010; tkeep = 32'h0000_0300;
        repeat (6) tick();
        idle();
        do_read(1, 1'b0, 1'b1, 5, 1'b0, 5, 1'b0, "coll_clear");
        do_read(1, 1'b0, 1'b0, 1, 1'b0, 1, 1'b0, "coll_after");

        do_read(3, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, "oor_ch3");
        do_read(2, 1'b0, 1'b0, 1, 1'b0, 1, 1'b0, "oor_keep");

        // reset in the middle of a packet
        tvalid = 4'b0001; tready = 4'b0001; tkeep = 32'h0000_00FF; tick();
        tlast = 4'b0001; rst = 1'b1; tick();
        rst = 1'b0; idle();
        repeat (2) tick();
        do_read(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, "rst_pkt");
        do_read(0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, "rst_byte");
        do_read(2, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, "rst_ch2");

        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 399) == 0);
            clear_all = ($urandom_range(0, 299) == 0);
            tvalid    = 4'($urandom);
            tready    = 4'($urandom) | 4'($urandom);
            tlast     = 4'($urandom) & 4'($urandom);
            tkeep     = $urandom;
            rd_req    = 1'($urandom_range(0, 1));
            rd_ch     = 2'($urandom);
            rd_sel    = 1'($urandom);
            rd_clear  = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst = 1'b0; clear_all = 1'b0; rd_req = 1'b0; rd_clear = 1'b0;
        idle();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
